// File: rtl/alien_march_ctrl_pkg.sv
// game_pkg: motion codes, march states and screen constants shared by the game blocks
package game_pkg;
  typedef logic [2:0] motion_t;
  localparam motion_t MOT_NONE  = 3'd0;
  localparam motion_t MOT_LEFT  = 3'd1;
  localparam motion_t MOT_RIGHT = 3'd2;
  localparam motion_t MOT_DOWN  = 3'd3;
  typedef enum logic [1:0] {IDLE, MARCH, DROP, HALT} march_state_e;
  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;
endpackage

// File: rtl/alien_march_ctrl_if.sv
// alien_march_ctrl_if: game-side inputs and march command outputs of the march controller
interface alien_march_ctrl_if #(parameter int PERIOD_W = 8);
  import game_pkg::*;
  logic frame_tick;
  logic enable;
  logic canLeft;
  logic canRight;
  logic killingAlien;
  logic victory;
  logic defeat;
  motion_t motion;
  logic halted;
  logic [PERIOD_W-1:0] period;
  modport master(output frame_tick, enable, canLeft, canRight, killingAlien, victory, defeat,
                 input motion, halted, period);
  modport slave(input frame_tick, enable, canLeft, canRight, killingAlien, victory, defeat,
                output motion, halted, period);
endinterface

// File: rtl/alien_march_ctrl_period.sv
// march_period_ctrl: march period that shrinks by one step per kill, floored at MIN_PERIOD
module march_period_ctrl #(
  parameter int PERIOD_W     = 8,
  parameter int BASE_PERIOD  = 30,
  parameter int MIN_PERIOD   = 2,
  parameter int KILL_SPEEDUP = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                killingAlien,
  input  logic                freeze,
  output logic [PERIOD_W-1:0] period
);
  logic kprev;
  // one saturating decrement per rising edge of killingAlien, computed wide so it cannot underflow
  always_ff @(posedge clk)
    if (reset) begin
      kprev  <= 1'b0;
      period <= PERIOD_W'(BASE_PERIOD);
    end else begin
      kprev <= killingAlien;
      if (killingAlien && !kprev && !freeze)
        period <= (int'(period) - KILL_SPEEDUP >= MIN_PERIOD) ? period - PERIOD_W'(KILL_SPEEDUP)
                                                               : PERIOD_W'(MIN_PERIOD);
    end
endmodule

// File: rtl/alien_march_ctrl.sv
// alien_march_ctrl: frame-paced LEFT/RIGHT/DOWN strobes for the alien formation
module alien_march_ctrl
  import game_pkg::*;
#(
  parameter int PERIOD_W     = 8,
  parameter int BASE_PERIOD  = 30,
  parameter int MIN_PERIOD   = 2,
  parameter int KILL_SPEEDUP = 1,
  parameter int DROP_STEPS   = 8
) (
  input logic clk,
  input logic reset,
  alien_march_ctrl_if.slave bus
);
  localparam int DW = $clog2(DROP_STEPS) + 1;
  march_state_e state, state_n;
  logic [PERIOD_W-1:0] fcnt, fcnt_n, period;
  logic [DW-1:0] dcnt, dcnt_n;
  motion_t dir, dir_n, motion, motion_n, flip;
  logic tick, can;
  march_period_ctrl #(
    .PERIOD_W(PERIOD_W), .BASE_PERIOD(BASE_PERIOD),
    .MIN_PERIOD(MIN_PERIOD), .KILL_SPEEDUP(KILL_SPEEDUP)
  ) u_period (
    .clk(clk), .reset(reset), .killingAlien(bus.killingAlien),
    .freeze(state == HALT), .period(period)
  );
  assign tick = bus.frame_tick & bus.enable;
  assign can = (dir == MOT_RIGHT) ? bus.canRight : bus.canLeft;
  assign flip = (dir == MOT_RIGHT) ? MOT_LEFT : MOT_RIGHT;
  assign bus.motion = motion;
  assign bus.halted = state == HALT;
  assign bus.period = period;
  // march state register and strobe output
  always_ff @(posedge clk)
    if (reset) begin
      state  <= IDLE;
      fcnt   <= '0;
      dcnt   <= '0;
      dir    <= MOT_RIGHT;
      motion <= MOT_NONE;
    end else begin
      state  <= state_n;
      fcnt   <= fcnt_n;
      dcnt   <= dcnt_n;
      dir    <= dir_n;
      motion <= motion_n;
    end
  // next state: halting wins over any step due in the same clk; the step test uses the current period
  always_comb begin
    state_n  = state;
    fcnt_n   = fcnt;
    dcnt_n   = dcnt;
    dir_n    = dir;
    motion_n = MOT_NONE;
    if (state != IDLE && state != HALT && (bus.victory || bus.defeat)) begin
      state_n = HALT;
    end else if (state == IDLE) begin
      state_n = bus.enable ? MARCH : IDLE;
      fcnt_n  = '0;
      dir_n   = MOT_RIGHT;
    end else if (state == MARCH && tick) begin
      if (fcnt >= period - PERIOD_W'(1)) begin
        fcnt_n = '0;
        if (can) begin
          motion_n = dir;
        end else begin
          motion_n = MOT_DOWN;
          if (DROP_STEPS == 1) begin
            dir_n = flip;
          end else begin
            dcnt_n  = DW'(DROP_STEPS - 1);
            state_n = DROP;
          end
        end
      end else begin
        fcnt_n = fcnt + PERIOD_W'(1);
      end
    end else if (state == DROP && tick) begin
      motion_n = MOT_DOWN;
      dcnt_n   = dcnt - DW'(1);
      if (dcnt == DW'(1)) begin
        dir_n   = flip;
        fcnt_n  = '0;
        state_n = MARCH;
      end
    end
  end
endmodule

// File: tb/tb_alien_march_ctrl.sv
// tb_alien_march_ctrl: scoreboard bench with a tick-level reference model of the march rules
module tb_alien_march_ctrl;
  import game_pkg::*;
  localparam int W = 8, BP = 4, MP = 2, KS = 1, DS = 3;
  typedef struct {int cyc; motion_t mot;} exp_t;
  typedef struct {int tick; motion_t mot;} seen_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  alien_march_ctrl_if #(.PERIOD_W(W)) bus();
  alien_march_ctrl #(
    .PERIOD_W(W), .BASE_PERIOD(BP), .MIN_PERIOD(MP), .KILL_SPEEDUP(KS), .DROP_STEPS(DS)
  ) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  exp_t expq[$];
  seen_t seen[$];
  int wt[$];
  motion_t wm[$];
  exp_t e;
  int cyc = 0, checks = 0, errors = 0, nticks = 0, phase = 0;
  logic en, cl, cr, kill, vic, def, rst_i;
  bit mon_on = 0;
  int m_mode, m_wait, m_downs, m_period;
  bit m_right, m_kprev;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d (cyc %0d)", name, got, want, cyc);
    end
  endtask

  // mode 0 idle, 1 marching (sweeping or dropping), 2 halted; m_wait counts frames since the last step
  task automatic model(input bit t);
    motion_t out;
    int p;
    bit k_rise;
    out = MOT_NONE;
    if (rst_i) begin
      m_mode = 0; m_wait = 0; m_downs = 0; m_right = 1; m_period = BP; m_kprev = 0;
      return;
    end
    p = m_period;
    k_rise = kill && !m_kprev;
    m_kprev = kill;
    if (m_mode != 2 && k_rise) m_period = (m_period - KS > MP) ? m_period - KS : MP;
    if (m_mode == 0) begin
      if (en) m_mode = 1;
    end else if (m_mode == 1) begin
      if (vic || def) m_mode = 2;
      else if (t && en) begin
        if (m_downs > 0) begin
          out = MOT_DOWN;
          m_downs--;
          if (m_downs == 0) begin m_right = !m_right; m_wait = 0; end
        end else begin
          m_wait++;
          if (m_wait >= p) begin
            m_wait = 0;
            if (m_right ? cr : cl) out = m_right ? MOT_RIGHT : MOT_LEFT;
            else begin
              out = MOT_DOWN;
              m_downs = DS - 1;
              if (m_downs == 0) m_right = !m_right;
            end
          end
        end
      end
    end
    if (out != MOT_NONE) expq.push_back('{cyc + 1, out});
  endtask

  task automatic clk1();
    bit t;
    @(negedge clk);
    #1;
    t = (phase == 9);
    phase = (phase + 1) % 10;
    if (t) nticks++;
    reset = rst_i;
    bus.frame_tick = t;
    bus.enable = en;
    bus.canLeft = cl;
    bus.canRight = cr;
    bus.killingAlien = kill;
    bus.victory = vic;
    bus.defeat = def;
    model(t);
  endtask

  task automatic run_until(input int n);
    while (nticks < n) clk1();
    clk1();
  endtask

  task automatic do_reset();
    rst_i = 1; en = 0; cl = 1; cr = 1; kill = 0; vic = 0; def = 0;
    clk1();
    rst_i = 0; nticks = 0; phase = 0; en = 1;
    seen.delete();
  endtask

  task automatic expect_seen(input string name);
    chk({name, "_count"}, seen.size(), wt.size());
    for (int i = 0; i < wt.size() && i < seen.size(); i++) begin
      chk({name, "_tick"}, seen[i].tick, wt[i]);
      chk({name, "_mot"}, int'(seen[i].mot), int'(wm[i]));
    end
  endtask

  // monitor: every strobe the DUT presents is matched against the head of the expectation queue
  always @(negedge clk)
    if (mon_on) begin
      if (bus.motion != MOT_NONE) begin
        seen.push_back('{nticks, bus.motion});
        if (expq.size() == 0) chk("unexpected_strobe", int'(bus.motion), 0);
        else begin
          e = expq.pop_front();
          chk("strobe_cyc", cyc, e.cyc);
          chk("strobe_mot", int'(bus.motion), int'(e.mot));
        end
      end else if (expq.size() > 0 && expq[0].cyc <= cyc) begin
        e = expq.pop_front();
        chk("missed_strobe", 0, int'(e.mot));
      end
      chk("halted", int'(bus.halted), int'(m_mode == 2));
      chk("period", int'(bus.period), m_period);
    end

  initial begin
    bus.frame_tick = 0; bus.enable = 0; bus.canLeft = 1; bus.canRight = 1;
    bus.killingAlien = 0; bus.victory = 0; bus.defeat = 0;
    do_reset();
    mon_on = 1;
    run_until(13);
    wt = '{4, 8, 12}; wm = '{MOT_RIGHT, MOT_RIGHT, MOT_RIGHT};
    expect_seen("sweep_right");

    do_reset();
    run_until(7);
    cr = 0;
    run_until(18);
    wt = '{4, 8, 9, 10, 14, 18};
    wm = '{MOT_RIGHT, MOT_DOWN, MOT_DOWN, MOT_DOWN, MOT_LEFT, MOT_LEFT};
    expect_seen("edge_drop");

    do_reset();
    for (int i = 0; i < 3; i++) begin
      kill = 1; clk1();
      kill = 0; clk1();
      chk("kill_pulse_period", int'(bus.period), (i == 0) ? 3 : 2);
      clk1();
    end

    do_reset();
    kill = 1;
    for (int i = 0; i < 25; i++) clk1();
    kill = 0;
    clk1();
    chk("kill_held_period", int'(bus.period), 3);

    do_reset();
    run_until(7);
    while (phase != 9) clk1();
    vic = 1; clk1();
    vic = 0; clk1();
    chk("victory_halted", int'(bus.halted), 1);
    run_until(14);
    wt = '{4}; wm = '{MOT_RIGHT};
    expect_seen("victory_no_strobe");
    do_reset();
    en = 0; clk1();
    chk("reset_unhalts", int'(bus.halted), 0);
    chk("reset_period", int'(bus.period), BP);

    do_reset();
    run_until(2);
    en = 0;
    run_until(7);
    en = 1;
    run_until(9);
    wt = '{9}; wm = '{MOT_RIGHT};
    expect_seen("enable_pause");

    do_reset();
    cr = 0;
    run_until(5);
    do_reset();
    en = 0; clk1();
    chk("mid_drop_reset_state", int'(dut.state), int'(IDLE));
    chk("mid_drop_reset_motion", int'(bus.motion), 0);

    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) en = !en;
      cl = 1'($urandom_range(0, 3) != 0);
      cr = 1'($urandom_range(0, 3) != 0);
      kill = 1'($urandom_range(0, 9) == 0);
      def = (i == 2600);
      vic = (i == 2700);
      clk1();
    end
    kill = 0; def = 0; vic = 0;
    clk1();
    clk1();
    chk("queue_drained", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
